// File: rtl/exec_ctrl_pkg.sv
// Shared decode tables for the execute control stage: bit indices, control bundle and
// the combinational decode function.
package exec_ctrl_pkg;

  localparam int unsigned TYPE_W_C = 12;
  localparam int unsigned CODE_W_C = 56;

  localparam int unsigned TYPE_I = 0, TYPE_R = 1, TYPE_RW = 2, TYPE_IW = 3, TYPE_LOAD = 4,
                          TYPE_STORE = 5, TYPE_BRANCH = 6, TYPE_LUI = 7, TYPE_AUIPC = 8,
                          TYPE_JAL = 9, TYPE_JALR = 10, TYPE_SYS = 11;

  localparam int unsigned CODE_ADD = 0, CODE_SUB = 1, CODE_SLL = 2, CODE_SLT = 3,
                          CODE_SLTU = 4, CODE_XOR = 5, CODE_SRL = 6, CODE_SRA = 7,
                          CODE_OR = 8, CODE_AND = 9, CODE_MUL = 10, CODE_MULH = 11,
                          CODE_DIV = 12, CODE_REM = 13, CODE_ADDW = 14, CODE_SUBW = 15,
                          CODE_SLLW = 16, CODE_SRLW = 17, CODE_SRAW = 18, CODE_MULW = 19,
                          CODE_DIVW = 20, CODE_REMW = 21, CODE_ADDI = 22, CODE_SLTI = 23,
                          CODE_SLTIU = 24, CODE_XORI = 25, CODE_ORI = 26, CODE_ANDI = 27,
                          CODE_SLLI = 28, CODE_SRLI = 29, CODE_SRAI = 30, CODE_ADDIW = 31,
                          CODE_SLLIW = 32, CODE_SRLIW = 33, CODE_SRAIW = 34, CODE_LB = 35,
                          CODE_LH = 36, CODE_LW = 37, CODE_LD = 38, CODE_LBU = 39,
                          CODE_LHU = 40, CODE_LWU = 41, CODE_SB = 42, CODE_SH = 43,
                          CODE_SW = 44, CODE_SD = 45, CODE_BEQ = 46, CODE_BNE = 47,
                          CODE_BLT = 48, CODE_BGE = 49, CODE_BLTU = 50, CODE_BGEU = 51,
                          CODE_LUI = 52, CODE_AUIPC = 53, CODE_JAL = 54, CODE_JALR = 55;

  localparam logic [14:0] ALU_ADD  = 15'h0001, ALU_SUB  = 15'h0002, ALU_SLL  = 15'h0004,
                          ALU_SLT  = 15'h0008, ALU_SLTU = 15'h0010, ALU_XOR  = 15'h0020,
                          ALU_SRL  = 15'h0040, ALU_SRA  = 15'h0080, ALU_MUL  = 15'h0100,
                          ALU_MULH = 15'h0200, ALU_DIV  = 15'h0400, ALU_REM  = 15'h0800,
                          ALU_OR   = 15'h1000, ALU_AND  = 15'h2000, ALU_PASS = 15'h4000;

  localparam logic [3:0] X1_RS1 = 4'b0001, X1_SEXT = 4'b0010, X1_PC = 4'b0100,
                         X1_ZERO = 4'b1000;

  localparam logic [5:0] X2_RS2 = 6'b000001, X2_RS2_6 = 6'b000010, X2_RS2_5 = 6'b000100,
                         X2_SEXT = 6'b001000, X2_IMM = 6'b010000, X2_FOUR = 6'b100000;

  typedef enum logic [1:0] {StIdle, StMcWait, StHold} state_e;

  typedef struct packed {
    logic        rd_write;
    logic        r1_read;
    logic        r2_read;
    logic        is_32bit;
    logic [14:0] alu_op;
    logic [3:0]  x1_src;
    logic [5:0]  x2_src;
    logic        illegal;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t decode_ctrl(input logic [TYPE_W_C-1:0] itype,
                                               input logic [CODE_W_C-1:0] icode,
                                               input logic en_muldiv);
    ctrl_bundle_t c;
    int unsigned  idx;
    logic         is_m;
    c   = '0;
    idx = 0;
    for (int unsigned i = 0; i < CODE_W_C; i++) begin
      if (icode[i]) idx = i;
    end
    is_m = icode[CODE_MUL] | icode[CODE_MULH] | icode[CODE_DIV] | icode[CODE_REM] |
           icode[CODE_MULW] | icode[CODE_DIVW] | icode[CODE_REMW];

    c.rd_write = itype[TYPE_I] | itype[TYPE_R] | itype[TYPE_RW] | itype[TYPE_IW] |
                 itype[TYPE_LOAD] | itype[TYPE_LUI] | itype[TYPE_AUIPC] | itype[TYPE_JAL] |
                 itype[TYPE_JALR];
    c.r1_read  = itype[TYPE_I] | itype[TYPE_R] | itype[TYPE_RW] | itype[TYPE_IW] |
                 itype[TYPE_LOAD] | itype[TYPE_STORE] | itype[TYPE_BRANCH] | itype[TYPE_JALR];
    c.r2_read  = itype[TYPE_R] | itype[TYPE_RW] | itype[TYPE_STORE] | itype[TYPE_BRANCH];

    // Operand routing is a property of the instruction class.
    c.x1_src = X1_RS1;
    c.x2_src = X2_RS2;
    if (itype[TYPE_I] | itype[TYPE_IW] | itype[TYPE_LOAD] | itype[TYPE_STORE] |
        itype[TYPE_LUI] | itype[TYPE_AUIPC]) c.x2_src = X2_IMM;
    if (itype[TYPE_JAL] | itype[TYPE_JALR]) begin
      c.x1_src = X1_PC;
      c.x2_src = X2_FOUR;
    end
    if (itype[TYPE_AUIPC]) c.x1_src = X1_PC;
    if (itype[TYPE_LUI])   c.x1_src = X1_ZERO;
    if (itype[TYPE_RW] | itype[TYPE_IW]) begin
      c.x1_src   = X1_SEXT;
      c.is_32bit = 1'b1;
    end
    if (itype[TYPE_RW]) c.x2_src = X2_SEXT;

    case (idx)
      CODE_ADD, CODE_ADDW, CODE_ADDI, CODE_ADDIW, CODE_LB, CODE_LH, CODE_LW, CODE_LD,
      CODE_LBU, CODE_LHU, CODE_LWU, CODE_SB, CODE_SH, CODE_SW, CODE_SD, CODE_AUIPC,
      CODE_JAL, CODE_JALR:                               c.alu_op = ALU_ADD;
      CODE_SUB, CODE_SUBW, CODE_BEQ, CODE_BNE:           c.alu_op = ALU_SUB;
      CODE_SLL, CODE_SLLW, CODE_SLLI, CODE_SLLIW:        c.alu_op = ALU_SLL;
      CODE_SLT, CODE_SLTI, CODE_BLT, CODE_BGE:           c.alu_op = ALU_SLT;
      CODE_SLTU, CODE_SLTIU, CODE_BLTU, CODE_BGEU:       c.alu_op = ALU_SLTU;
      CODE_XOR, CODE_XORI:                               c.alu_op = ALU_XOR;
      CODE_SRL, CODE_SRLW, CODE_SRLI, CODE_SRLIW:        c.alu_op = ALU_SRL;
      CODE_SRA, CODE_SRAW, CODE_SRAI, CODE_SRAIW:        c.alu_op = ALU_SRA;
      CODE_OR, CODE_ORI:                                 c.alu_op = ALU_OR;
      CODE_AND, CODE_ANDI:                               c.alu_op = ALU_AND;
      CODE_MUL, CODE_MULW:                               c.alu_op = ALU_MUL;
      CODE_MULH:                                         c.alu_op = ALU_MULH;
      CODE_DIV, CODE_DIVW:                               c.alu_op = ALU_DIV;
      CODE_REM, CODE_REMW:                               c.alu_op = ALU_REM;
      CODE_LUI:                                          c.alu_op = ALU_PASS;
      default:                                           c.alu_op = '0;
    endcase

    // Register-register shifts only use the low shamt bits of rs2.
    if ((c.alu_op & (ALU_SLL | ALU_SRL | ALU_SRA)) != '0) begin
      if (itype[TYPE_R])  c.x2_src = X2_RS2_6;
      if (itype[TYPE_RW]) c.x2_src = X2_RS2_5;
    end

    if (!$onehot(itype) || !$onehot(icode) || (is_m && !en_muldiv)) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mc_latency_cnt.sv
// Down-counter that times multi-cycle M-extension ops; done flags the last wait cycle.
module mc_latency_cnt
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/exec_ctrl_seq.sv
// Registered, handshaked execute-control stage: decodes one-hot type/code into a control
// bundle, holds it in one output register and stalls for multi-cycle mul/div ops.
module exec_ctrl_seq
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned TYPE_W    = TYPE_W_C,
  parameter int unsigned CODE_W    = CODE_W_C,
  parameter int unsigned EN_MULDIV = 1,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_LAT   = 33
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [TYPE_W-1:0] i_instr_type,
  input  logic [CODE_W-1:0] i_instr_code,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_rd_write,
  output logic              o_r1_read,
  output logic              o_r2_read,
  output logic              o_is_32bit,
  output logic [14:0]       o_alu_op,
  output logic [3:0]        o_alu_x1_src,
  output logic [5:0]        o_alu_x2_src,
  output logic              o_illegal,
  output logic              o_mc_busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic        MUL_MC  = (MUL_LAT > 1);
  localparam logic        DIV_MC  = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e       r_state;
  logic         r_out_valid;
  logic         r_mc_busy;
  ctrl_bundle_t r_bundle;

  ctrl_bundle_t     w_dec;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_go_mc;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_done;

  assign w_dec    = decode_ctrl(i_instr_type, i_instr_code, EN_MULDIV != 0);
  // Illegal ops never take the multi-cycle path, so gate the class on legality.
  assign w_is_mul = ~w_dec.illegal & (i_instr_code[CODE_MUL] | i_instr_code[CODE_MULH] |
                                      i_instr_code[CODE_MULW]);
  assign w_is_div = ~w_dec.illegal & (i_instr_code[CODE_DIV] | i_instr_code[CODE_REM] |
                                      i_instr_code[CODE_DIVW] | i_instr_code[CODE_REMW]);
  assign w_go_mc    = (w_is_mul & MUL_MC) | (w_is_div & DIV_MC);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_cnt_load = w_accept & w_go_mc;
  assign w_load_val = w_is_div ? DIV_LOAD : MUL_LOAD;

  always_comb begin
    o_in_ready = 1'b0;
    case (r_state)
      StIdle:  o_in_ready = ~i_flush;
      StHold:  o_in_ready = i_out_ready & ~i_flush;
      default: o_in_ready = 1'b0;
    endcase
  end

  mc_latency_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_flush),
    .i_load     (w_cnt_load),
    .i_load_val (w_load_val),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_mc_busy   <= 1'b0;
      r_bundle    <= '0;
    end else if (i_flush) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_mc_busy   <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StHold: begin
          // In HOLD an accept implies out_ready, so the held bundle is consumed too.
          if (w_accept) begin
            r_bundle <= w_dec;
            if (w_go_mc) begin
              r_state     <= StMcWait;
              r_out_valid <= 1'b0;
              r_mc_busy   <= 1'b1;
            end else begin
              r_state     <= StHold;
              r_out_valid <= 1'b1;
              r_mc_busy   <= 1'b0;
            end
          end else if (r_state == StHold && i_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        StMcWait: begin
          if (w_cnt_done) begin
            r_state     <= StHold;
            r_out_valid <= 1'b1;
            r_mc_busy   <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_mc_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_mc_busy    = r_mc_busy;
  assign o_rd_write   = r_bundle.rd_write;
  assign o_r1_read    = r_bundle.r1_read;
  assign o_r2_read    = r_bundle.r2_read;
  assign o_is_32bit   = r_bundle.is_32bit;
  assign o_alu_op     = r_bundle.alu_op;
  assign o_alu_x1_src = r_bundle.x1_src;
  assign o_alu_x2_src = r_bundle.x2_src;
  assign o_illegal    = r_bundle.illegal;

endmodule

// File: tb/tb_exec_ctrl_seq.sv
// Directed bench for exec_ctrl_seq: one instance with M ops enabled, one with them disabled.
module tb_exec_ctrl_seq;

  localparam int T_R = 1, T_RW = 2;
  localparam int C_ADD = 0, C_SUB = 1, C_AND = 9, C_DIV = 12, C_REM = 13, C_MULW = 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] instr_type;
  logic [55:0] instr_code;
  logic        out_valid;
  logic        out_ready;
  logic        rd_write, r1_read, r2_read, is_32bit, illegal, mc_busy;
  logic [14:0] alu_op;
  logic [3:0]  x1_src;
  logic [5:0]  x2_src;

  logic        n_in_ready, n_out_valid, n_rd_write, n_r1_read, n_r2_read, n_is_32bit;
  logic        n_illegal, n_mc_busy;
  logic [14:0] n_alu_op;
  logic [3:0]  n_x1_src;
  logic [5:0]  n_x2_src;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  exec_ctrl_seq #(
    .EN_MULDIV (1),
    .MUL_LAT   (3),
    .DIV_LAT   (33)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_instr_type (instr_type),
    .i_instr_code (instr_code),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_rd_write   (rd_write),
    .o_r1_read    (r1_read),
    .o_r2_read    (r2_read),
    .o_is_32bit   (is_32bit),
    .o_alu_op     (alu_op),
    .o_alu_x1_src (x1_src),
    .o_alu_x2_src (x2_src),
    .o_illegal    (illegal),
    .o_mc_busy    (mc_busy)
  );

  exec_ctrl_seq #(
    .EN_MULDIV (0),
    .MUL_LAT   (3),
    .DIV_LAT   (33)
  ) u_dut_nomd (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (n_in_ready),
    .i_instr_type (instr_type),
    .i_instr_code (instr_code),
    .o_out_valid  (n_out_valid),
    .i_out_ready  (out_ready),
    .o_rd_write   (n_rd_write),
    .o_r1_read    (n_r1_read),
    .o_r2_read    (n_r2_read),
    .o_is_32bit   (n_is_32bit),
    .o_alu_op     (n_alu_op),
    .o_alu_x1_src (n_x1_src),
    .o_alu_x2_src (n_x2_src),
    .o_illegal    (n_illegal),
    .o_mc_busy    (n_mc_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int t, input int c);
    in_valid   = v;
    instr_type = '0;
    instr_code = '0;
    if (v) begin
      instr_type[t] = 1'b1;
      instr_code[c] = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 0);
    tick(); tick();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_mc_busy", mc_busy, 1'b0);
    check_eq("rst_alu_op", alu_op, 15'h0000);
    check_eq("rst_illegal", illegal, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // Single ADD
    drive(1'b1, T_R, C_ADD);
    #1 check_eq("add_in_ready", in_ready, 1'b1);
    tick();
    check_eq("add_valid", out_valid, 1'b1);
    check_eq("add_alu_op", alu_op, 15'h0001);
    check_eq("add_x1", x1_src, 4'b0001);
    check_eq("add_x2", x2_src, 6'b000001);
    check_eq("add_rd_write", rd_write, 1'b1);
    check_eq("add_r1_read", r1_read, 1'b1);
    check_eq("add_r2_read", r2_read, 1'b1);
    check_eq("add_is_32bit", is_32bit, 1'b0);
    drive(1'b0, 0, 0);
    tick();
    check_eq("add_consumed", out_valid, 1'b0);

    // Back-to-back ADD/SUB/AND
    drive(1'b1, T_R, C_ADD);
    tick();
    check_eq("b2b_add_valid", out_valid, 1'b1);
    check_eq("b2b_add_op", alu_op, 15'h0001);
    drive(1'b1, T_R, C_SUB);
    tick();
    check_eq("b2b_sub_valid", out_valid, 1'b1);
    check_eq("b2b_sub_op", alu_op, 15'h0002);
    drive(1'b1, T_R, C_AND);
    tick();
    check_eq("b2b_and_valid", out_valid, 1'b1);
    check_eq("b2b_and_op", alu_op, 15'h2000);
    drive(1'b0, 0, 0);
    tick();
    check_eq("b2b_drain", out_valid, 1'b0);

    // MULW, three-cycle latency
    drive(1'b1, T_RW, C_MULW);
    tick();
    drive(1'b0, 0, 0);
    #1;
    for (int c = 1; c <= 2; c++) begin
      check_eq($sformatf("mulw_c%0d_busy", c), mc_busy, 1'b1);
      check_eq($sformatf("mulw_c%0d_in_ready", c), in_ready, 1'b0);
      check_eq($sformatf("mulw_c%0d_valid", c), out_valid, 1'b0);
      tick();
    end
    check_eq("mulw_valid", out_valid, 1'b1);
    check_eq("mulw_busy_done", mc_busy, 1'b0);
    check_eq("mulw_alu_op", alu_op, 15'h0100);
    check_eq("mulw_is_32bit", is_32bit, 1'b1);
    check_eq("mulw_x1", x1_src, 4'b0010);
    check_eq("mulw_x2", x2_src, 6'b001000);
    tick();
    check_eq("mulw_consumed", out_valid, 1'b0);

    // DIV flushed at cycle 10, flush beats a same-cycle ADD
    drive(1'b1, T_R, C_DIV);
    tick();
    drive(1'b0, 0, 0);
    for (int c = 1; c < 9; c++) tick();
    check_eq("div_c9_busy", mc_busy, 1'b1);
    check_eq("div_c9_valid", out_valid, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, T_R, C_ADD);
    #1 check_eq("flush_in_ready", in_ready, 1'b0);
    tick();
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_busy", mc_busy, 1'b0);
    flush = 1'b0;
    drive(1'b0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      seen = seen | out_valid;
    end
    check_eq("flush_no_output", seen, 1'b0);
    drive(1'b1, T_R, C_ADD);
    tick();
    check_eq("post_flush_add_valid", out_valid, 1'b1);
    check_eq("post_flush_add_op", alu_op, 15'h0001);
    drive(1'b0, 0, 0);
    tick();

    // Illegal: two code bits set
    drive(1'b1, T_R, C_ADD);
    instr_code[C_SUB] = 1'b1;
    tick();
    check_eq("ill2_valid", out_valid, 1'b1);
    check_eq("ill2_illegal", illegal, 1'b1);
    check_eq("ill2_rd_write", rd_write, 1'b0);
    check_eq("ill2_alu_op", alu_op, 15'h0000);
    check_eq("ill2_busy", mc_busy, 1'b0);
    drive(1'b0, 0, 0);
    tick();

    // REM: illegal single-cycle without M ops, 33-cycle op with them
    drive(1'b1, T_R, C_REM);
    tick();
    drive(1'b0, 0, 0);
    check_eq("nomd_rem_valid", n_out_valid, 1'b1);
    check_eq("nomd_rem_illegal", n_illegal, 1'b1);
    check_eq("nomd_rem_rd_write", n_rd_write, 1'b0);
    check_eq("nomd_rem_alu_op", n_alu_op, 15'h0000);
    check_eq("nomd_rem_busy", n_mc_busy, 1'b0);
    check_eq("rem_busy", mc_busy, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("rem_valid", out_valid, 1'b1);
    check_eq("rem_wait_cycles", n, 32);
    check_eq("rem_alu_op", alu_op, 15'h0800);
    check_eq("rem_illegal", illegal, 1'b0);
    tick();
    check_eq("rem_consumed", out_valid, 1'b0);

    // HOLD stall with out_ready low
    out_ready = 1'b0;
    drive(1'b1, T_R, C_ADD);
    tick();
    drive(1'b1, T_R, C_SUB);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("stall%0d_valid", c), out_valid, 1'b1);
      check_eq($sformatf("stall%0d_op", c), alu_op, 15'h0001);
      check_eq($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
      tick();
    end
    drive(1'b0, 0, 0);
    out_ready = 1'b1;
    tick();
    check_eq("stall_consumed", out_valid, 1'b0);

    // Async reset while holding an illegal bundle
    out_ready = 1'b0;
    drive(1'b1, T_R, C_ADD);
    instr_code[C_AND] = 1'b1;
    tick();
    drive(1'b0, 0, 0);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    check_eq("pre_rst_illegal", illegal, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    check_eq("arst_illegal", illegal, 1'b0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Async reset mid multi-cycle op aborts it
    drive(1'b1, T_R, C_DIV);
    tick();
    drive(1'b0, 0, 0);
    tick(); tick();
    check_eq("arst_div_busy_before", mc_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_div_busy", mc_busy, 1'b0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      seen = seen | out_valid;
    end
    check_eq("arst_div_no_output", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
